// File: rtl/rb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rb_pkg
// Description : Shared constants and state encoding for the row-buffer
//               write/read path (write controller, control unit, read
//               address generator).
// Revision    : 1.0 - initial release
// ============================================================================
package rb_pkg;

  // Default geometry: square image, IMAGE_WIDTH pixels per row and per frame
  localparam int IMAGE_WIDTH_DEF = 256;
  localparam int RB_COUNT_DEF    = 8;
  localparam int DATA_W_DEF      = 8;

  // Derived widths for the default geometry
  localparam int COL_W_DEF = $clog2(IMAGE_WIDTH_DEF);
  localparam int RB_W_DEF  = $clog2(RB_COUNT_DEF);

  // Write-side frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rb_credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : rb_credit_counter
// Description : Free-row credit counter. Starts full, decrements on row
//               completion, increments on row release, saturates at both
//               ends and raises a sticky error on a release while full.
// Revision    : 1.0 - initial release
// ============================================================================
module rb_credit_counter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] credits,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(MAX);

  // Credit bookkeeping: simultaneous inc/dec cancel; overflow flags err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= FULL;
      err     <= 1'b0;
    end else if (inc && !dec) begin
      if (credits == FULL) begin
        err <= 1'b1;
      end else begin
        credits <= credits + 1'b1;
      end
    end else if (dec && !inc) begin
      if (credits != '0) begin
        credits <= credits - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rb_write_ctrl
// Description : Row-buffer write stage. Places accepted pixels into the
//               current row buffer, rotates buffers per row, honours free-row
//               credits from the read side and signals frame fill/done.
// Revision    : 1.0 - initial release
// ============================================================================
module rb_write_ctrl
  import rb_pkg::*;
#(
  parameter int IMAGE_WIDTH = IMAGE_WIDTH_DEF,
  parameter int RB_COUNT    = RB_COUNT_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_W,
  input  logic                           pix_valid,
  input  logic [DATA_W-1:0]              pix_data,
  output logic                           pix_ready,
  input  logic                           row_release,
  output logic [RB_COUNT-1:0]            wr_en,
  output logic [$clog2(IMAGE_WIDTH)-1:0] wr_addr,
  output logic [DATA_W-1:0]              wr_data,
  output logic [$clog2(RB_COUNT)-1:0]    wr_rb_sel,
  output logic                           W_frame_filled,
  output logic                           frame_done,
  output logic [$clog2(IMAGE_WIDTH):0]   row_cnt,
  output logic                           credit_err
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int RB_W  = $clog2(RB_COUNT);
  localparam int RC_W  = COL_W + 1;
  localparam int CR_W  = $clog2(RB_COUNT + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [RB_W-1:0]  RB_LAST   = RB_W'(RB_COUNT - 1);
  localparam logic [RC_W-1:0]  ROW_FINAL = RC_W'(IMAGE_WIDTH - 1);
  localparam logic [RC_W-1:0]  ROW_FILL  = RC_W'(RB_COUNT - 1);
  localparam logic [RC_W-1:0]  ROW_MAX   = RC_W'(IMAGE_WIDTH);
  localparam logic [CR_W-1:0]  CR_ONE    = CR_W'(1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [RB_W-1:0]   rb;
  logic              filled_flag;
  logic [CR_W-1:0]   credits;
  logic              accept;
  logic              last_col;
  logic              row_done;
  logic              final_row;
  logic              credits_run_out;

  assign pix_ready       = (state == WRITE) && en_W && (credits != '0);
  assign accept          = pix_valid && pix_ready;
  assign last_col        = (col == COL_LAST);
  assign row_done        = accept && last_col;
  assign final_row       = (row_cnt == ROW_FINAL);
  // The row finishing now consumes the last credit and nothing comes back
  assign credits_run_out = (credits == CR_ONE) && !row_release;

  rb_credit_counter #(
    .MAX (RB_COUNT),
    .CW  (CR_W)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .dec     (row_done),
    .inc     (row_release),
    .credits (credits),
    .err     (credit_err)
  );

  // Registered BRAM write port: one-cycle strobe per accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_rb_sel <= '0;
    end else begin
      wr_en <= '0;
      if (accept) begin
        wr_en     <= RB_COUNT'(1) << rb;
        wr_addr   <= col;
        wr_data   <= pix_data;
        wr_rb_sel <= rb;
      end
    end
  end

  // Frame sequencing, position counters and fill/done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      col            <= '0;
      rb             <= '0;
      row_cnt        <= '0;
      filled_flag    <= 1'b0;
      frame_done     <= 1'b0;
      W_frame_filled <= 1'b0;
    end else begin
      W_frame_filled <= 1'b0;

      if (accept) begin
        if (last_col) begin
          col <= '0;
          rb  <= (rb == RB_LAST) ? '0 : rb + 1'b1;
          if (row_cnt != ROW_MAX) begin
            row_cnt <= row_cnt + 1'b1;
          end
          // Row RB_COUNT-1 completing means every buffer holds a row
          if ((row_cnt == ROW_FILL) && !filled_flag) begin
            W_frame_filled <= 1'b1;
            filled_flag    <= 1'b1;
          end
          if (final_row) begin
            frame_done <= 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (en_W) state <= WRITE;
        end
        WRITE: begin
          if (row_done) begin
            if (final_row) begin
              state <= DONE;
            end else if (credits_run_out) begin
              state <= STALL;
            end
          end
        end
        STALL: begin
          if (credits != '0) state <= WRITE;
        end
        DONE: begin
          if (!en_W) begin
            state       <= IDLE;
            col         <= '0;
            rb          <= '0;
            row_cnt     <= '0;
            filled_flag <= 1'b0;
            frame_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rb_write_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rb_write_ctrl
// Description : Self-checking bench for rb_write_ctrl. Instance A uses the
//               default geometry (256x256, 8 buffers), instance B a small one
//               (16x16, 4 buffers) for credit-stall behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rb_write_ctrl;
  import rb_pkg::*;

  localparam int AW = 256;
  localparam int AR = 8;
  localparam int BW = 16;
  localparam int BR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // ---------------- instance A (defaults) ----------------
  logic       a_rst, a_en, a_valid, a_rel;
  logic [7:0] a_data;
  logic       a_ready;
  logic [7:0] a_wr_en, a_wr_addr, a_wr_data;
  logic [2:0] a_sel;
  logic       a_wff, a_fd, a_err;
  logic [8:0] a_rowcnt;

  rb_write_ctrl dut_a (
    .clk(clk), .rst(a_rst), .en_W(a_en), .pix_valid(a_valid), .pix_data(a_data),
    .pix_ready(a_ready), .row_release(a_rel), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_rb_sel(a_sel), .W_frame_filled(a_wff),
    .frame_done(a_fd), .row_cnt(a_rowcnt), .credit_err(a_err)
  );

  // ---------------- instance B (16x16, 4 buffers) ----------------
  logic       b_rst, b_en, b_valid, b_rel;
  logic [7:0] b_data;
  logic       b_ready;
  logic [3:0] b_wr_en, b_wr_addr;
  logic [7:0] b_wr_data;
  logic [1:0] b_sel;
  logic       b_wff, b_fd, b_err;
  logic [4:0] b_rowcnt;

  rb_write_ctrl #(.IMAGE_WIDTH(BW), .RB_COUNT(BR), .DATA_W(8)) dut_b (
    .clk(clk), .rst(b_rst), .en_W(b_en), .pix_valid(b_valid), .pix_data(b_data),
    .pix_ready(b_ready), .row_release(b_rel), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_rb_sel(b_sel), .W_frame_filled(b_wff),
    .frame_done(b_fd), .row_cnt(b_rowcnt), .credit_err(b_err)
  );

  // ---------------- reference model for instance A ----------------
  // Frame progress is tracked as a linear count of accepted pixels; column,
  // buffer and row are derived from it arithmetically.
  int         m_n;
  int         m_credits;
  bit         m_err, m_inframe, m_stall, m_done;
  bit         e_ready, o_ready;
  logic [7:0] e_wen, e_addr, e_data;
  logic [2:0] e_sel;
  bit         e_wff, e_fd;
  logic [8:0] e_rowcnt;
  logic [38:0] a_exp;
  logic [38:0] a_obs;

  assign a_obs = {a_wr_en, a_wff, a_fd, a_rowcnt, a_err,
                  (a_wr_en != 8'h0) ? {a_wr_addr, a_wr_data, a_sel} : 19'h0};

  task automatic model_reset_a();
    m_n = 0; m_credits = AR; m_err = 1'b0;
    m_inframe = 1'b0; m_stall = 1'b0; m_done = 1'b0;
    e_addr = '0; e_data = '0; e_sel = '0;
    a_exp = '0;
  endtask

  // Drive one cycle on A (from a negedge), advance the model, end at negedge
  task automatic step_a(input bit en, input bit v, input bit rel);
    bit acc, row_done, last_px;
    int old_cr;
    a_en = en; a_valid = v; a_rel = rel; a_data = 8'($urandom);
    #1;
    o_ready  = a_ready;
    e_ready  = m_inframe && !m_stall && !m_done && en && (m_credits > 0);
    acc      = v && e_ready;
    row_done = acc && (m_n % AW == AW - 1);
    last_px  = acc && (m_n == AW * AW - 1);
    e_wen    = acc ? 8'(1 << ((m_n / AW) % AR)) : 8'h0;
    if (acc) begin
      e_addr = 8'(m_n % AW);
      e_data = a_data;
      e_sel  = 3'((m_n / AW) % AR);
    end
    e_wff  = acc && (m_n + 1 == AR * AW);
    old_cr = m_credits;
    if (rel && !row_done) begin
      if (m_credits == AR) m_err = 1'b1;
      else m_credits++;
    end else if (row_done && !rel) begin
      m_credits--;
    end
    if (acc) m_n++;
    if (!m_inframe) m_inframe = en;
    else if (m_done) begin
      if (!en) begin m_inframe = 1'b0; m_done = 1'b0; m_n = 0; end
    end else if (m_stall) begin
      if (old_cr > 0) m_stall = 1'b0;
    end else if (row_done) begin
      if (last_px) m_done = 1'b1;
      else if (m_credits == 0) m_stall = 1'b1;
    end
    e_fd     = m_done;
    e_rowcnt = 9'(m_n / AW);
    a_exp = {e_wen, e_wff, e_fd, e_rowcnt, m_err,
             (e_wen != 8'h0) ? {e_addr, e_data, e_sel} : 19'h0};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset_a();
    a_rst = 1'b1; a_en = 1'b0; a_valid = 1'b0; a_rel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    model_reset_a();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_en = 0; a_valid = 0; a_rel = 0; a_data = 0;
    b_en = 0; b_valid = 0; b_rel = 0; b_data = 0;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if ({a_ready, a_obs} !== 40'h0) $display("FAIL reset_a_outputs got=%h want=0", {a_ready, a_obs}); else n_pass++;
    n_chk++; if (dut_a.credits !== 4'd8) $display("FAIL reset_a_credits got=%0d want=8", dut_a.credits); else n_pass++;
    n_chk++; if (dut_a.state !== IDLE) $display("FAIL reset_a_state got=%0d want=%0d", dut_a.state, IDLE); else n_pass++;
    n_chk++; if ({b_ready, b_wr_en, b_wr_addr, b_wr_data, b_sel, b_wff, b_fd, b_rowcnt, b_err} !== 28'h0)
      $display("FAIL reset_b_outputs got=%h want=0", {b_ready, b_wr_en, b_wr_addr, b_wr_data, b_sel, b_wff, b_fd, b_rowcnt, b_err}); else n_pass++;
    a_rst = 1'b0; b_rst = 1'b0;
    model_reset_a();
  endtask

  task automatic test_idle_release();
    step_a(1'b0, 1'b0, 1'b1);
    n_chk++; if (a_err !== 1'b1) $display("FAIL idle_release_err got=%b want=1", a_err); else n_pass++;
    n_chk++; if (dut_a.credits !== 4'd8) $display("FAIL idle_release_credits got=%0d want=8", dut_a.credits); else n_pass++;
    for (int i = 0; i < 4; i++) step_a(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    n_chk++; if ({o_ready, a_obs} !== {e_ready, a_exp}) $display("FAIL idle_release_hold got=%h want=%h", {o_ready, a_obs}, {e_ready, a_exp}); else n_pass++;
  endtask

  task automatic test_pause();
    int bad = 0;
    for (int i = 0; i < 4000 && m_n < 3 * AW + 100; i++) begin
      step_a(1'b1, $urandom_range(0, 3) != 0, 1'b0);
      n_chk++; if ({o_ready, a_obs} !== {e_ready, a_exp}) $display("FAIL pause_run got=%h want=%h", {o_ready, a_obs}, {e_ready, a_exp}); else n_pass++;
    end
    n_chk++; if (a_rowcnt !== 9'd3) $display("FAIL pause_rowcnt got=%0d want=3", a_rowcnt); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step_a(1'b0, 1'b1, 1'b0);
      if (o_ready !== 1'b0 || a_wr_en !== 8'h0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL pause_gap got=%0d active cycles want=0", bad); else n_pass++;
    step_a(1'b1, 1'b1, 1'b0);
    n_chk++; if ({a_wr_en, a_wr_addr, a_sel} !== {8'h08, 8'd100, 3'd3})
      $display("FAIL pause_resume got=en%h addr%0d rb%0d want=en08 addr100 rb3", a_wr_en, a_wr_addr, a_sel); else n_pass++;
  endtask

  task automatic test_async_reset();
    int w = 0, wff_cnt = 0;
    bit first = 1'b1;
    for (int i = 0; i < 4000 && m_n < 5 * AW + 37; i++) begin
      step_a(1'b1, $urandom_range(0, 3) != 0, 1'b0);
      n_chk++; if ({o_ready, a_obs} !== {e_ready, a_exp}) $display("FAIL arst_pre got=%h want=%h", {o_ready, a_obs}, {e_ready, a_exp}); else n_pass++;
    end
    n_chk++; if (a_rowcnt !== 9'd5) $display("FAIL arst_rowcnt got=%0d want=5", a_rowcnt); else n_pass++;
    a_en = 1'b1; a_valid = 1'b1;
    #2;
    a_rst = 1'b1;
    #1;
    n_chk++; if ({a_ready, a_obs} !== 40'h0) $display("FAIL arst_immediate got=%h want=0", {a_ready, a_obs}); else n_pass++;
    n_chk++; if (dut_a.credits !== 4'd8) $display("FAIL arst_credits got=%0d want=8", dut_a.credits); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    model_reset_a();
    for (int i = 0; i < 8000 && m_n < AR * AW; i++) begin
      step_a(1'b1, $urandom_range(0, 3) != 0, (m_credits < AR) && ($urandom_range(0, 7) == 0));
      n_chk++; if ({o_ready, a_obs} !== {e_ready, a_exp}) $display("FAIL arst_post got=%h want=%h", {o_ready, a_obs}, {e_ready, a_exp}); else n_pass++;
      if (a_wr_en != 8'h0) begin
        w++;
        if (first) begin
          first = 1'b0;
          n_chk++; if ({a_wr_en, a_wr_addr, a_sel} !== {8'h01, 8'd0, 3'd0})
            $display("FAIL arst_first_write got=en%h addr%0d rb%0d want=en01 addr0 rb0", a_wr_en, a_wr_addr, a_sel); else n_pass++;
        end
      end
      if (a_wff) begin
        wff_cnt++;
        n_chk++; if (w != AR * AW) $display("FAIL arst_filled_at got=%0d want=%0d", w, AR * AW); else n_pass++;
      end
    end
    n_chk++; if (wff_cnt != 1) $display("FAIL arst_filled_count got=%0d want=1", wff_cnt); else n_pass++;
  endtask

  task automatic test_same_cycle();
    pulse_reset_a();
    for (int i = 0; i < 3000 && m_n < 8 * AW; i++) begin
      step_a(1'b1, 1'b1, m_n == 8 * AW - 1);
      n_chk++; if ({o_ready, a_obs} !== {e_ready, a_exp}) $display("FAIL same_cycle_run got=%h want=%h", {o_ready, a_obs}, {e_ready, a_exp}); else n_pass++;
    end
    n_chk++; if (dut_a.credits !== 4'd1) $display("FAIL same_cycle_credits got=%0d want=1", dut_a.credits); else n_pass++;
    n_chk++; if (a_err !== 1'b0) $display("FAIL same_cycle_err got=%b want=0", a_err); else n_pass++;
    step_a(1'b1, 1'b1, 1'b0);
    n_chk++; if ({o_ready, a_wr_en} !== {1'b1, 8'h01}) $display("FAIL same_cycle_nostall got=rdy%b en%h want=rdy1 en01", o_ready, a_wr_en); else n_pass++;
  endtask

  task automatic test_full_frame();
    int w = 0, wff_cnt = 0, prev;
    bit pend = 1'b0, fd_seen = 1'b0;
    pulse_reset_a();
    for (int i = 0; i < 70000 && !m_done; i++) begin
      prev = m_n;
      step_a(1'b1, 1'b1, pend);
      pend = (m_n != prev) && (m_n % AW == 0);
      n_chk++; if ({o_ready, a_obs} !== {e_ready, a_exp}) $display("FAIL full_run got=%h want=%h", {o_ready, a_obs}, {e_ready, a_exp}); else n_pass++;
      if (a_wr_en != 8'h0) w++;
      if (a_wff) begin
        wff_cnt++;
        n_chk++; if (w != AR * AW) $display("FAIL full_filled_at got=%0d want=%0d", w, AR * AW); else n_pass++;
      end
      if (a_fd && !fd_seen) begin
        fd_seen = 1'b1;
        n_chk++; if (w != AW * AW) $display("FAIL full_done_at got=%0d want=%0d", w, AW * AW); else n_pass++;
      end
    end
    n_chk++; if (w != AW * AW) $display("FAIL full_writes got=%0d want=%0d", w, AW * AW); else n_pass++;
    n_chk++; if (wff_cnt != 1) $display("FAIL full_filled_count got=%0d want=1", wff_cnt); else n_pass++;
    n_chk++; if (!fd_seen) $display("FAIL full_done_seen got=0 want=1"); else n_pass++;
    step_a(1'b1, 1'b1, pend);
    n_chk++; if ({o_ready, a_fd} !== 2'b01) $display("FAIL full_done_hold got=rdy%b fd%b want=rdy0 fd1", o_ready, a_fd); else n_pass++;
    step_a(1'b0, 1'b0, 1'b0);
    n_chk++; if ({a_fd, a_rowcnt} !== 10'h0) $display("FAIL full_idle_clear got=fd%b rows%0d want=fd0 rows0", a_fd, a_rowcnt); else n_pass++;
  endtask

  task automatic test_stall_small();
    int wb = 0, bad = 0;
    b_en = 1'b1; b_valid = 1'b1; b_rel = 1'b0;
    for (int i = 0; i < 100; i++) begin
      b_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (b_wr_en != 4'h0) wb++;
    end
    n_chk++; if (wb != BR * BW) $display("FAIL stall_writes got=%0d want=%0d", wb, BR * BW); else n_pass++;
    n_chk++; if ({b_ready, b_rowcnt} !== {1'b0, 5'd4}) $display("FAIL stall_ready got=rdy%b rows%0d want=rdy0 rows4", b_ready, b_rowcnt); else n_pass++;
    n_chk++; if (dut_b.state !== STALL) $display("FAIL stall_state got=%0d want=%0d", dut_b.state, STALL); else n_pass++;
    b_rel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_rel = 1'b0;
    wb = 0;
    for (int i = 0; i < 40; i++) begin
      b_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (b_wr_en != 4'h0) begin
        wb++;
        if (b_wr_en !== 4'h1 || b_sel !== 2'd0) bad++;
      end
    end
    n_chk++; if (wb != BW) $display("FAIL stall_release_writes got=%0d want=%0d", wb, BW); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL stall_release_rb got=%0d off-buffer writes want=0", bad); else n_pass++;
    n_chk++; if ({b_ready, b_rowcnt, b_err} !== {1'b0, 5'd5, 1'b0}) $display("FAIL stall_again got=rdy%b rows%0d err%b want=rdy0 rows5 err0", b_ready, b_rowcnt, b_err); else n_pass++;
    n_chk++; if (dut_b.state !== STALL) $display("FAIL stall_again_state got=%0d want=%0d", dut_b.state, STALL); else n_pass++;
  endtask

  initial begin
    model_reset_a();
    test_reset();
    test_idle_release();
    test_pause();
    test_async_reset();
    test_same_cycle();
    test_stall_small();
    test_full_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
